fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the core. It owns the PC and issues word requests to instruction memory.
- It buffers returned instructions and presents them to decode as instr_D / pc_D.
- It acts on the PCSrcE redirect code (predict-taken / mispredict recovery) and produces branched_flag_F for the decoder.
- It is the producer side of the decode interface: everything the decoder consumes (op, funct3, funct7b5, branched_flag_F) originates here.

Parameters:
- XLEN, 32, PC and instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  XLEN  word-aligned fetch address (= pc)
- imem_rsp_valid  in  1  response data valid; exactly one response per accepted request, at least 1 cycle after acceptance
- imem_rsp_data  in  32  fetched instruction
- PCSrcE  in  2  00 increment, 01 predicted-taken redirect, 10 mispredict recovery, 11 illegal
- target_D  in  XLEN  branch/jump target computed in decode (used when PCSrcE=01)
- recovery_pc_E  in  XLEN  fall-through PC of the mispredicted branch (used when PCSrcE=10)
- stall_D  in  1  decode cannot accept the instruction this cycle
- valid_D  out  1  instr_D/pc_D valid
- instr_D  out  32  instruction to decode
- pc_D  out  XLEN  PC of instr_D
- branched_flag_F  out  1  instr_D is the first instruction fetched after a predicted-taken redirect

Behaviour:
- Reset (synchronous, clk edge while reset=1):
  - pc=RESET_PC, state=IDLE, FIFO empty.
  - Outputs: valid_D=0, instr_D=32'h0000_0013 (NOP), pc_D=0, branched_flag_F=0, imem_req_valid=0.
  - Reset mid-transaction abandons any outstanding request; a response arriving after reset deasserts is dropped (state IDLE, no outstanding request).
- FIFO: 2 entries of {instr, pc, bflag}.
  - Head drives valid_D/instr_D/pc_D/branched_flag_F.
  - Pop when valid_D && !stall_D.
  - Write on an accepted response; the entry is visible the next cycle. Simultaneous push and pop are allowed.
- Request gating: imem_req_valid = (state==IDLE) && (count_after_pop + 0 < 2) && !reset.
  - At most one outstanding request.
  - imem_req_addr = pc (combinational).
- FSM:
  - IDLE: a request accepted (valid&&ready) -> WAIT, pc <= pc+4.
  - WAIT: on rsp_valid, push {data, address of request, pending_bflag} and go to IDLE; pending_bflag then clears.
  - DISCARD: on rsp_valid, drop the data and go to IDLE.
- Redirect (PCSrcE=01 or 10, evaluated every cycle, 10 has priority):
  - FIFO flushed; valid_D=0 next cycle.
  - pc <= target_D (01) or recovery_pc_E (10).
  - pending_bflag <= 1 for 01, 0 for 10.
  - Next state: IDLE -> IDLE (the unaccepted request address simply changes; a request accepted in the same cycle is treated as outstanding and stale -> DISCARD). WAIT without rsp_valid -> DISCARD. WAIT with rsp_valid -> response dropped, IDLE. DISCARD -> DISCARD.
  - Redirect beats a same-cycle push and pop: nothing is pushed, and a pop is ignored.
- PCSrcE=11 behaves as 00; a simulation assertion fires.
- pc arithmetic is XLEN-bit wrap-around: 32'hFFFF_FFFC + 4 = 0.
- Throughput:
  - Zero-wait memory gives one instruction per 2 cycles (single outstanding request).
  - Best case: 1 cycle from reset deassert to the first request; valid_D 1 cycle after rsp_valid.

Decomposition:
- skylark_pkg:
  - enum pcsrc_t {PC_INC=2'b00, PC_PREDICT=2'b01, PC_RECOVER=2'b10}
  - NOP_INSTR = 32'h0000_0013
  - fetch_state_t {IDLE, WAIT, DISCARD}
  - fetch entry struct
- Sub-module fetch_fifo: 2-entry synchronous FIFO with flush, push, pop, count; parameterised on entry width.

Test Plan:
- Reset release, zero-latency memory returning addr-derived data -> requests at 0x0, 0x4, 0x8; valid_D pulses with pc_D=0x0, 0x4, 0x8; branched_flag_F=0.
- stall_D held high for 6 cycles -> exactly 2 entries buffered, no further imem_req_valid; after release pc_D continues 0x0, 0x4 without loss or duplication.
- PCSrcE=01, target_D=0x100, while request 0x8 is outstanding -> 0x8 response discarded; next valid_D has pc_D=0x100, branched_flag_F=1; following instr at 0x104 has branched_flag_F=0.
- PCSrcE=10, recovery_pc_E=0x20, in the same cycle as rsp_valid -> response dropped, FIFO empty next cycle, next request addr=0x20, branched_flag_F=0.
- Reset asserted while in WAIT, response arrives 2 cycles after reset deasserts -> response ignored; first valid_D has pc_D=RESET_PC.
- RESET_PC=32'hFFFF_FFFC -> second request address wraps to 0x0.

Source files
------------

// File: rtl/skylark_pkg.sv
// Shared types and constants for the skylark fetch path.
package skylark_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned INSTR_W  = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      PC_INC     = 2'b00,
      PC_PREDICT = 2'b01,
      PC_RECOVER = 2'b10
   } pcsrc_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DISCARD
   } fetch_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0]  instr;
      logic [XLEN_DEF-1:0] pc;
      logic                bflag;
   } fetch_entry_t;

   localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry shift-register FIFO; the head always sits in slot 0.
module fetch_fifo #(
   parameter int unsigned   W         = 8,
   parameter logic [W-1:0]  RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic         valid,
   output logic [1:0]   count
);

   logic [W-1:0] data0;
   logic [W-1:0] data1;

   // Storage and occupancy; emptied slots return to RESET_VAL so the head reads idle values.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         count <= 2'd0;
         data0 <= RESET_VAL;
         data1 <= RESET_VAL;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) data0 <= din;
               else               data1 <= din;
               count <= count + 2'd1;
            end
            2'b01: begin
               data0 <= (count == 2'd2) ? data1 : RESET_VAL;
               data1 <= RESET_VAL;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd2) begin
                  data0 <= data1;
                  data1 <= din;
               end else begin
                  data0 <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign head  = data0;
   assign valid = (count != 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues single-outstanding imem requests,
// buffers responses for decode and applies predict/recover redirects.
module fetch_unit
   import skylark_pkg::*;
#(
   parameter int unsigned      XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [XLEN-1:0]  imem_req_addr,
   input  logic             imem_rsp_valid,
   input  logic [31:0]      imem_rsp_data,
   input  logic [1:0]       PCSrcE,
   input  logic [XLEN-1:0]  target_D,
   input  logic [XLEN-1:0]  recovery_pc_E,
   input  logic             stall_D,
   output logic             valid_D,
   output logic [31:0]      instr_D,
   output logic [XLEN-1:0]  pc_D,
   output logic             branched_flag_F
);

   localparam fetch_entry_t IDLE_ENTRY = '{instr: NOP_INSTR, pc: '0, bflag: 1'b0};

   fetch_state_t     state;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  req_addr;
   logic             pending_bflag;

   logic             redirect_pred;
   logic             redirect_rec;
   logic             redirect;
   logic             req_fire;
   logic             pop_raw;
   logic             pop;
   logic             push;
   logic [1:0]       count;
   logic [1:0]       count_after_pop;
   logic             head_valid;
   logic [ENTRY_W-1:0] head_bits;
   fetch_entry_t     head_entry;
   fetch_entry_t     wr_entry;

   // Redirect decode; recovery outranks prediction, 11 falls through as increment.
   assign redirect_rec  = (PCSrcE == PC_RECOVER);
   assign redirect_pred = (PCSrcE == PC_PREDICT);
   assign redirect      = redirect_rec || redirect_pred;

   // Handshakes and FIFO control; a redirect suppresses both push and pop.
   assign pop_raw         = head_valid && !stall_D;
   assign pop             = pop_raw && !redirect;
   assign push            = (state == WAIT) && imem_rsp_valid && !redirect;
   assign count_after_pop = count - 2'(pop_raw);
   assign imem_req_valid  = (state == IDLE) && (count_after_pop < 2'd2) && !reset;
   assign imem_req_addr   = pc;
   assign req_fire        = imem_req_valid && imem_req_ready;

   assign wr_entry = '{instr: imem_rsp_data, pc: req_addr, bflag: pending_bflag};

   fetch_fifo #(
      .W         (ENTRY_W),
      .RESET_VAL (IDLE_ENTRY)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (redirect),
      .push  (push),
      .pop   (pop),
      .din   (wr_entry),
      .head  (head_bits),
      .valid (head_valid),
      .count (count)
   );

   assign head_entry      = fetch_entry_t'(head_bits);
   assign valid_D         = head_valid;
   assign instr_D         = head_entry.instr;
   assign pc_D            = XLEN'(head_entry.pc);
   assign branched_flag_F = head_entry.bflag;

   // Fetch FSM, PC and branched-flag tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         pc            <= RESET_PC;
         req_addr      <= '0;
         pending_bflag <= 1'b0;
      end else begin
         if (req_fire) req_addr <= pc;
         if (redirect) begin
            pc            <= redirect_rec ? recovery_pc_E : target_D;
            pending_bflag <= !redirect_rec;
            case (state)
               IDLE:    state <= req_fire ? DISCARD : IDLE;
               WAIT:    state <= imem_rsp_valid ? IDLE : DISCARD;
               DISCARD: state <= imem_rsp_valid ? IDLE : DISCARD;
               default: state <= IDLE;
            endcase
         end else begin
            if (req_fire) pc <= pc + XLEN'(4);
            if (push)     pending_bflag <= 1'b0;
            case (state)
               IDLE:    if (req_fire)       state <= WAIT;
               WAIT:    if (imem_rsp_valid) state <= IDLE;
               DISCARD: if (imem_rsp_valid) state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Flag the reserved redirect encoding in simulation.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (PCSrcE != 2'b11) else $error("fetch_unit: reserved PCSrcE encoding 11");
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch stream, stall back-pressure,
// predict/recover redirects, reset mid-request and PC wrap.
module tb_fetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: RESET_PC = 0
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic [1:0]  pcsrc;
   logic [31:0] target;
   logic [31:0] recovery;
   logic        stall;
   logic        vld;
   logic [31:0] instr;
   logic [31:0] pcd;
   logic        bflag;

   // Instance B: RESET_PC = FFFF_FFFC
   logic        b_reset;
   logic        b_req_valid;
   logic        b_req_ready;
   logic [31:0] b_req_addr;
   logic        b_rsp_valid;
   logic [31:0] b_rsp_data;
   logic [1:0]  b_pcsrc;
   logic [31:0] b_target;
   logic [31:0] b_recovery;
   logic        b_stall;
   logic        b_vld;
   logic [31:0] b_instr;
   logic [31:0] b_pcd;
   logic        b_bflag;

   int errors = 0;
   int checks = 0;

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (req_valid),
      .imem_req_ready  (req_ready),
      .imem_req_addr   (req_addr),
      .imem_rsp_valid  (rsp_valid),
      .imem_rsp_data   (rsp_data),
      .PCSrcE          (pcsrc),
      .target_D        (target),
      .recovery_pc_E   (recovery),
      .stall_D         (stall),
      .valid_D         (vld),
      .instr_D         (instr),
      .pc_D            (pcd),
      .branched_flag_F (bflag)
   );

   fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
      .clk             (clk),
      .reset           (b_reset),
      .imem_req_valid  (b_req_valid),
      .imem_req_ready  (b_req_ready),
      .imem_req_addr   (b_req_addr),
      .imem_rsp_valid  (b_rsp_valid),
      .imem_rsp_data   (b_rsp_data),
      .PCSrcE          (b_pcsrc),
      .target_D        (b_target),
      .recovery_pc_E   (b_recovery),
      .stall_D         (b_stall),
      .valid_D         (b_vld),
      .instr_D         (b_instr),
      .pc_D            (b_pcd),
      .branched_flag_F (b_bflag)
   );

   // Memory contents are derived from the address so stale data is recognisable.
   function automatic logic [31:0] dat(input logic [31:0] a);
      return 32'hA500_0000 | a;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic rst, input logic rdy, input logic rv,
                         input logic [31:0] rd, input logic [1:0] src, input logic st);
      reset     = rst;
      req_ready = rdy;
      rsp_valid = rv;
      rsp_data  = rd;
      pcsrc     = src;
      stall     = st;
      #1;
   endtask

   task automatic expd(input string tag, input logic v, input logic [31:0] p,
                       input logic [31:0] ins, input logic bf);
      chk({tag, ".valid_D"}, 32'(vld), 32'(v));
      if (v) begin
         chk({tag, ".pc_D"}, pcd, p);
         chk({tag, ".instr_D"}, instr, ins);
         chk({tag, ".bflag"}, 32'(bflag), 32'(bf));
      end
   endtask

   task automatic expr(input string tag, input logic v, input logic [31:0] a);
      chk({tag, ".req_valid"}, 32'(req_valid), 32'(v));
      if (v) chk({tag, ".req_addr"}, req_addr, a);
   endtask

   initial begin
      target      = '0;
      recovery    = '0;
      b_reset     = 1'b1;
      b_req_ready = 1'b0;
      b_rsp_valid = 1'b0;
      b_rsp_data  = '0;
      b_pcsrc     = 2'b00;
      b_target    = '0;
      b_recovery  = '0;
      b_stall     = 1'b0;

      // Reset values
      set_in(1, 0, 0, 0, 2'b00, 0);
      tick(); tick();
      chk("rst.valid_D", 32'(vld), 32'd0);
      chk("rst.instr_D", instr, 32'h0000_0013);
      chk("rst.pc_D", pcd, 32'd0);
      chk("rst.bflag", 32'(bflag), 32'd0);
      chk("rst.req_valid", 32'(req_valid), 32'd0);

      // Zero-latency stream: 0x0, 0x4, 0x8
      tick(); set_in(0, 1, 0, 0, 2'b00, 0);          expr("s1c0", 1, 32'h0);
      tick(); set_in(0, 1, 1, dat(32'h0), 2'b00, 0); expr("s1c1", 0, 0); expd("s1c1", 0, 0, 0, 0);
      tick(); set_in(0, 1, 0, 0, 2'b00, 0);          expd("s1c2", 1, 32'h0, dat(32'h0), 0); expr("s1c2", 1, 32'h4);
      tick(); set_in(0, 1, 1, dat(32'h4), 2'b00, 0); expd("s1c3", 0, 0, 0, 0);
      tick(); set_in(0, 1, 0, 0, 2'b00, 0);          expd("s1c4", 1, 32'h4, dat(32'h4), 0); expr("s1c4", 1, 32'h8);
      tick(); set_in(0, 1, 1, dat(32'h8), 2'b00, 0);
      tick(); set_in(0, 0, 0, 0, 2'b00, 0);          expd("s1c6", 1, 32'h8, dat(32'h8), 0);

      // Stall back-pressure: FIFO fills to 2, requests stop
      tick(); set_in(1, 0, 0, 0, 2'b00, 0);
      tick(); set_in(0, 1, 0, 0, 2'b00, 1);          expr("s2c0", 1, 32'h0);
      tick(); set_in(0, 1, 1, dat(32'h0), 2'b00, 1);
      tick(); set_in(0, 1, 0, 0, 2'b00, 1);          expd("s2c2", 1, 32'h0, dat(32'h0), 0); expr("s2c2", 1, 32'h4);
      tick(); set_in(0, 1, 1, dat(32'h4), 2'b00, 1);
      tick(); set_in(0, 1, 0, 0, 2'b00, 1);          expr("s2c4", 0, 0); expd("s2c4", 1, 32'h0, dat(32'h0), 0);
      tick(); set_in(0, 1, 0, 0, 2'b00, 1);          expr("s2c5", 0, 0);
      tick(); set_in(0, 0, 0, 0, 2'b00, 0);          expd("s2c6", 1, 32'h0, dat(32'h0), 0); expr("s2c6", 1, 32'h8);
      tick(); set_in(0, 0, 0, 0, 2'b00, 0);          expd("s2c7", 1, 32'h4, dat(32'h4), 0);
      tick(); set_in(0, 0, 0, 0, 2'b00, 0);          expd("s2c8", 0, 0, 0, 0);

      // Predicted-taken redirect while 0x8 is outstanding
      tick(); set_in(1, 0, 0, 0, 2'b00, 0);
      tick(); set_in(0, 1, 0, 0, 2'b00, 0);          expr("s3c0", 1, 32'h0);
      tick(); set_in(0, 1, 1, dat(32'h0), 2'b00, 0);
      tick(); set_in(0, 1, 0, 0, 2'b00, 0);          expd("s3c2", 1, 32'h0, dat(32'h0), 0); expr("s3c2", 1, 32'h4);
      tick(); set_in(0, 1, 1, dat(32'h4), 2'b00, 0);
      tick(); set_in(0, 1, 0, 0, 2'b00, 0);          expd("s3c4", 1, 32'h4, dat(32'h4), 0); expr("s3c4", 1, 32'h8);
      tick(); target = 32'h100;
              set_in(0, 1, 0, 0, 2'b01, 0);          expr("s3c5", 0, 0);
      tick(); set_in(0, 1, 1, dat(32'h8), 2'b00, 0); expr("s3c6", 0, 0);
      tick(); set_in(0, 1, 0, 0, 2'b00, 0);          expd("s3c7", 0, 0, 0, 0); expr("s3c7", 1, 32'h100);
      tick(); set_in(0, 1, 1, dat(32'h100), 2'b00, 0);
      tick(); set_in(0, 1, 0, 0, 2'b00, 0);          expd("s3c9", 1, 32'h100, dat(32'h100), 1); expr("s3c9", 1, 32'h104);
      tick(); set_in(0, 1, 1, dat(32'h104), 2'b00, 0);
      tick(); set_in(0, 1, 0, 0, 2'b00, 1);          expd("s3c11", 1, 32'h104, dat(32'h104), 0); expr("s3c11", 1, 32'h108);

      // Recovery redirect in the same cycle as the response; FIFO flushed
      tick(); recovery = 32'h20;
              set_in(0, 1, 1, dat(32'h108), 2'b10, 1); expr("s4c12", 0, 0);
      tick(); set_in(0, 1, 0, 0, 2'b00, 0);          expd("s4c13", 0, 0, 0, 0); expr("s4c13", 1, 32'h20);
      tick(); set_in(0, 1, 1, dat(32'h20), 2'b00, 0);
      tick(); set_in(0, 1, 0, 0, 2'b00, 0);          expd("s4c15", 1, 32'h20, dat(32'h20), 0); expr("s4c15", 1, 32'h24);

      // Reset while waiting on 0x24; late response must be ignored
      tick(); set_in(1, 0, 0, 0, 2'b00, 0);          expr("s5c16", 0, 0);
      tick(); set_in(0, 0, 0, 0, 2'b00, 0);          expd("s5c17", 0, 0, 0, 0);
                                                      chk("s5c17.instr_D", instr, 32'h0000_0013);
                                                      chk("s5c17.pc_D", pcd, 32'h0);
                                                      expr("s5c17", 1, 32'h0);
      tick(); set_in(0, 0, 0, 0, 2'b00, 0);
      tick(); set_in(0, 0, 1, dat(32'h24), 2'b00, 0);
      tick(); set_in(0, 1, 0, 0, 2'b00, 0);          expd("s5c20", 0, 0, 0, 0); expr("s5c20", 1, 32'h0);
      tick(); set_in(0, 1, 1, dat(32'h0), 2'b00, 0);
      tick(); set_in(0, 0, 0, 0, 2'b00, 0);          expd("s5c22", 1, 32'h0, dat(32'h0), 0);

      // PC wrap from FFFF_FFFC
      tick(); b_reset = 1'b0; b_req_ready = 1'b1; #1;
      chk("s6.req_valid0", 32'(b_req_valid), 32'd1);
      chk("s6.req_addr0", b_req_addr, 32'hFFFF_FFFC);
      tick(); b_rsp_valid = 1'b1; b_rsp_data = 32'h1234_5678; #1;
      chk("s6.req_valid_wait", 32'(b_req_valid), 32'd0);
      tick(); b_rsp_valid = 1'b0; #1;
      chk("s6.valid_D", 32'(b_vld), 32'd1);
      chk("s6.pc_D", b_pcd, 32'hFFFF_FFFC);
      chk("s6.instr_D", b_instr, 32'h1234_5678);
      chk("s6.req_valid1", 32'(b_req_valid), 32'd1);
      chk("s6.req_addr1", b_req_addr, 32'h0000_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
